spi_shift_engine: RTL and testbench
===================================

SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

Interface
REQ-001 SHALL have ports (clock and reset first): wb_clk_in  input  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have wb_rst  input  1  asynchronous, active-low reset; clears all state immediately on assertion.
REQ-003 SHALL have go  input  1  start request, sampled each clock; honoured only when tip=0.
REQ-004 SHALL have len  input  5  character length; 1-31 = that many bits, 0 = 32 bits; sampled when go is accepted.
REQ-005 SHALL have lsb  input  1  1 = LSB first, 0 = MSB first; sampled when go is accepted.
REQ-006 SHALL have tx_negedge  input  1  1 = s_out changes at sclk falling edges, 0 = at rising edges.
REQ-007 SHALL have rx_negedge  input  1  1 = s_in sampled at sclk falling edges, 0 = at rising edges.
REQ-008 SHALL have cpol_0  input  1  one-clock strobe from the clock generator; the clkgen raises sclk on the same clock edge.
REQ-009 SHALL have cpol_1  input  1  one-clock strobe from the clock generator; the clkgen lowers sclk on the same clock edge.
REQ-010 SHALL have tx_data  input  32  transmit word; captured when go is accepted.
REQ-011 SHALL have s_in  input  1  serial data in (MISO).
REQ-012 SHALL have tip  output  1  transfer in progress; drives the clock generator tip input.
REQ-013 SHALL have last_clk  output  1  final-period flag; drives the clock generator last_clk input.
REQ-014 SHALL have s_out  output  1  serial data out (MOSI).
REQ-015 SHALL have rx_data  output  32  received word.
REQ-016 SHALL have done  output  1  one-clock pulse at transfer completion.

Function
REQ-017 Definitions: N = len, or 32 if len=0; rx strobe = rx_negedge ? cpol_1 : cpol_0; tx strobe = tx_negedge ? cpol_1 : cpol_0.
REQ-018 States: IDLE (tip=0) and XFER (tip=1); no other states.
REQ-019 IDLE->XFER on the clock where go=1: tip<=1; bit_cnt<=N; tx_idx<=1; sampled<=0; rx_data<=0; tx word, N and lsb latched.
REQ-020 On the same clock, s_out SHALL present the first bit: tx_data[0] if lsb=1, else tx_data[N-1].
REQ-021 go while tip=1 SHALL be ignored; it SHALL NOT alter latched data, counters or rx_data.
REQ-022 bit_cnt (6 bits) SHALL decrement by 1 on each cpol_0 while tip=1 and bit_cnt>0; it never wraps below 0.
REQ-023 last_clk SHALL equal tip AND (bit_cnt==0), decoded from registers with no extra latency.
REQ-024 On each rx strobe while tip=1, sample k (k=0..N-1) SHALL be written to rx_data[k] if lsb=1, or to rx_data[N-1-k] if lsb=0; set sampled<=1.
REQ-025 rx_data bits at positions >= N SHALL remain 0.
REQ-026 On a tx strobe while tip=1, sampled=1 and tx_idx<N: s_out<=next bit (index tx_idx if lsb=1, else N-1-tx_idx); tx_idx<=tx_idx+1.
REQ-027 On any other tx strobe, s_out SHALL hold its value.
REQ-028 XFER->IDLE on the clock where cpol_1=1 and bit_cnt==0: tip<=0, done<=1 for exactly one clock, after the final rx sample is stored.
REQ-029 cpol_0/cpol_1 while tip=0 SHALL be ignored.
REQ-030 cpol_0 and cpol_1 both asserted in one clock SHALL be ignored entirely.
REQ-031 s_out and rx_data SHALL hold their values after completion until the next accepted go.
REQ-032 go on the clock immediately after done SHALL be accepted.

Reset
REQ-033 While wb_rst=0: tip=0, last_clk=0, s_out=0, done=0, rx_data=0, bit_cnt=0, tx_idx=0, sampled=0.
REQ-034 Reset asserted mid-transfer SHALL abort it immediately with no done pulse; the first go after release starts a clean transfer.

Verification
REQ-035 Mode 0 (tx_negedge=1, rx_negedge=0), len=8, lsb=0, tx_data=0xA5, s_in looped to s_out -> s_out bit sequence 1,0,1,0,0,1,0,1; rx_data=0x000000A5; one done pulse; 8 cpol_0 strobes consumed.
REQ-036 tx_negedge=0, rx_negedge=1, len=0, lsb=1, tx_data=0x12345678, loopback -> rx_data=0x12345678; tip high for exactly 32 sclk periods.
REQ-037 len=4, lsb=1, s_in tied 1 -> rx_data=0x0000000F; last_clk rises on the clock of the 4th cpol_0 and falls with tip.
REQ-038 go pulsed mid-transfer with tx_data changed to 0xFF -> ongoing 0xA5 transfer completes unchanged; no second transfer starts.
REQ-039 wb_rst low after 3 bits of an 8-bit transfer -> all outputs 0 at once, no done; next go with 0x3C completes with rx_data=0x3C.
REQ-040 cpol_0 and cpol_1 pulsed with tip=0 -> no state or output change.

Source files
------------

// File: rtl/spi_shift_engine_if.sv
// SPI shift engine bus: control, clock-generator strobes, serial lines and results.
// Ports: go/len/lsb/tx_negedge/rx_negedge/tx_data (control), cpol_0/cpol_1 (sclk strobes),
//        s_in/s_out (serial), tip/last_clk/done/rx_data (status and result).
interface spi_shift_engine_if;
    logic        go;
    logic [4:0]  len;
    logic        lsb;
    logic        tx_negedge;
    logic        rx_negedge;
    logic        cpol_0;
    logic        cpol_1;
    logic [31:0] tx_data;
    logic        s_in;
    logic        tip;
    logic        last_clk;
    logic        s_out;
    logic [31:0] rx_data;
    logic        done;

    modport slave (
        input  go, len, lsb, tx_negedge, rx_negedge, cpol_0, cpol_1, tx_data, s_in,
        output tip, last_clk, s_out, rx_data, done
    );

    modport master (
        output go, len, lsb, tx_negedge, rx_negedge, cpol_0, cpol_1, tx_data, s_in,
        input  tip, last_clk, s_out, rx_data, done
    );
endinterface

// File: rtl/spi_shift_engine.sv
// SPI shift engine: serialises tx_data onto s_out and assembles s_in into rx_data.
// Latency: first bit on s_out the clock go is accepted; done pulses one clock after the final cpol_1.
// Backpressure: go is ignored while tip=1; bit timing is paced entirely by cpol_0/cpol_1 strobes.
// Ports: wb_clk_in (clock), wb_rst (async active-low reset), bus (slave modport of spi_shift_engine_if).
module spi_shift_engine (
    input  logic                 wb_clk_in,
    input  logic                 wb_rst,
    spi_shift_engine_if.slave    bus
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [5:0]  tx_idx_q, tx_idx_d;
    logic [5:0]  rx_idx_q, rx_idx_d;
    logic [4:0]  n_m1_q, n_m1_d;        // character length minus one
    logic        lsb_q, lsb_d;
    logic        sampled_q, sampled_d;
    logic        s_out_q, s_out_d;
    logic        done_q, done_d;
    logic [31:0] tx_word_q, tx_word_d;
    logic [31:0] rx_data_q, rx_data_d;

    logic        c0, c1, rx_stb, tx_stb;
    logic [5:0]  len_n;
    logic [4:0]  len_m1;
    logic [4:0]  first_pos;
    logic [4:0]  tx_pos, rx_pos;

    // len=0 encodes 32; the 5-bit len-1 wraps 0 to 31, which is exactly N-1 in that case.
    assign len_n  = (bus.len == 5'd0) ? 6'd32 : {1'b0, bus.len};
    assign len_m1 = bus.len - 5'd1;

    // Simultaneous strobes are treated as no strobe at all.
    assign c0     = bus.cpol_0 & ~bus.cpol_1;
    assign c1     = bus.cpol_1 & ~bus.cpol_0;
    assign rx_stb = bus.rx_negedge ? c1 : c0;
    assign tx_stb = bus.tx_negedge ? c1 : c0;

    assign first_pos = bus.lsb ? 5'd0 : len_m1;
    assign tx_pos    = lsb_q ? tx_idx_q[4:0] : (n_m1_q - tx_idx_q[4:0]);
    assign rx_pos    = lsb_q ? rx_idx_q[4:0] : (n_m1_q - rx_idx_q[4:0]);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tx_idx_d  = tx_idx_q;
        rx_idx_d  = rx_idx_q;
        n_m1_d    = n_m1_q;
        lsb_d     = lsb_q;
        sampled_d = sampled_q;
        s_out_d   = s_out_q;
        done_d    = 1'b0;
        tx_word_d = tx_word_q;
        rx_data_d = rx_data_q;

        case (state_q)
            IDLE: begin
                if (bus.go) begin
                    state_d   = XFER;
                    bit_cnt_d = len_n;
                    tx_idx_d  = 6'd1;
                    rx_idx_d  = 6'd0;
                    sampled_d = 1'b0;
                    rx_data_d = 32'd0;
                    tx_word_d = bus.tx_data;
                    n_m1_d    = len_m1;
                    lsb_d     = bus.lsb;
                    s_out_d   = bus.tx_data[first_pos];
                end
            end
            XFER: begin
                if (rx_stb && (rx_idx_q <= {1'b0, n_m1_q})) begin
                    rx_data_d[rx_pos] = bus.s_in;
                    rx_idx_d          = rx_idx_q + 6'd1;
                    sampled_d         = 1'b1;
                end
                // Never shift out before the first bit has been sampled by the far end.
                if (tx_stb && sampled_q && (tx_idx_q <= {1'b0, n_m1_q})) begin
                    s_out_d  = tx_word_q[tx_pos];
                    tx_idx_d = tx_idx_q + 6'd1;
                end
                if (c0 && (bit_cnt_q != 6'd0)) begin
                    bit_cnt_d = bit_cnt_q - 6'd1;
                end
                if (c1 && (bit_cnt_q == 6'd0)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_in or negedge wb_rst) begin
        if (!wb_rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= 6'd0;
            tx_idx_q  <= 6'd0;
            rx_idx_q  <= 6'd0;
            n_m1_q    <= 5'd0;
            lsb_q     <= 1'b0;
            sampled_q <= 1'b0;
            s_out_q   <= 1'b0;
            done_q    <= 1'b0;
            tx_word_q <= 32'd0;
            rx_data_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tx_idx_q  <= tx_idx_d;
            rx_idx_q  <= rx_idx_d;
            n_m1_q    <= n_m1_d;
            lsb_q     <= lsb_d;
            sampled_q <= sampled_d;
            s_out_q   <= s_out_d;
            done_q    <= done_d;
            tx_word_q <= tx_word_d;
            rx_data_q <= rx_data_d;
        end
    end

    assign bus.tip      = (state_q == XFER);
    assign bus.last_clk = (state_q == XFER) && (bit_cnt_q == 6'd0);
    assign bus.s_out    = s_out_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine with a behavioural sclk strobe generator.
// Each scenario task drives a transfer and checks results against hand-computed values.
module tb_spi_shift_engine;

    logic clk;
    logic rst_n;
    logic loop;
    logic sin_fix;

    spi_shift_engine_if bus ();

    spi_shift_engine dut (
        .wb_clk_in (clk),
        .wb_rst    (rst_n),
        .bus       (bus)
    );

    assign bus.s_in = loop ? bus.s_out : sin_fix;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          errors;
    int          dones;
    int          periods;
    int          c0s;
    int          first_last;
    int          nseq;
    int          go_at;
    int          both_at;
    logic [31:0] seq;

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.done) dones++;
        if (bus.last_clk && first_last < 0) first_last = c0s;
    endtask

    task automatic record();
        if (nseq < 32) seq[nseq] = bus.s_in;
        nseq++;
    endtask

    task automatic start(input logic [4:0] l, input logic lb, input logic [31:0] d);
        bus.len     = l;
        bus.lsb     = lb;
        bus.tx_data = d;
        bus.go      = 1'b1;
        dones       = 0;
        tick();
        bus.go      = 1'b0;
    endtask

    // Models the clock generator: rise strobe, idle clock, fall strobe, idle clock.
    task automatic run_clkgen(input int max_p);
        periods    = 0;
        c0s        = 0;
        nseq       = 0;
        seq        = 32'd0;
        first_last = -1;
        while (bus.tip && periods < max_p) begin
            bus.cpol_0 = 1'b1;
            if (!bus.rx_negedge) record();
            c0s++;
            tick();
            bus.cpol_0 = 1'b0;
            if (periods == go_at) begin
                bus.go      = 1'b1;
                bus.tx_data = 32'hFF;
                tick();
                bus.go      = 1'b0;
            end else begin
                tick();
            end
            bus.cpol_1 = 1'b1;
            if (bus.rx_negedge) record();
            tick();
            bus.cpol_1 = 1'b0;
            if (bus.tip && periods == both_at) begin
                bus.cpol_0 = 1'b1;
                bus.cpol_1 = 1'b1;
                tick();
                bus.cpol_0 = 1'b0;
                bus.cpol_1 = 1'b0;
            end
            periods++;
            if (bus.tip) tick();
        end
    endtask

    task automatic set_mode(input logic txn, input logic rxn, input logic lp, input logic sf);
        bus.tx_negedge = txn;
        bus.rx_negedge = rxn;
        loop           = lp;
        sin_fix        = sf;
        go_at          = -1;
        both_at        = -1;
    endtask

    task automatic test_reset();
        checks += 5;
        if (bus.tip !== 1'b0) begin errors++; $display("FAIL reset_tip got %b want 0", bus.tip); end
        if (bus.last_clk !== 1'b0) begin errors++; $display("FAIL reset_last_clk got %b want 0", bus.last_clk); end
        if (bus.s_out !== 1'b0) begin errors++; $display("FAIL reset_s_out got %b want 0", bus.s_out); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        if (bus.rx_data !== 32'd0) begin errors++; $display("FAIL reset_rx_data got %h want 0", bus.rx_data); end
    endtask

    task automatic test_mode0();
        set_mode(1'b1, 1'b0, 1'b1, 1'b0);
        start(5'd8, 1'b0, 32'hA5);
        checks += 3;
        if (bus.tip !== 1'b1) begin errors++; $display("FAIL m0_tip_start got %b want 1", bus.tip); end
        if (bus.s_out !== 1'b1) begin errors++; $display("FAIL m0_first_bit got %b want 1", bus.s_out); end
        if (bus.rx_data !== 32'd0) begin errors++; $display("FAIL m0_rx_clear got %h want 0", bus.rx_data); end
        run_clkgen(40);
        tick();
        checks += 6;
        if (bus.tip !== 1'b0) begin errors++; $display("FAIL m0_tip_end got %b want 0", bus.tip); end
        if (nseq !== 8) begin errors++; $display("FAIL m0_nbits got %0d want 8", nseq); end
        if (seq[7:0] !== 8'hA5) begin errors++; $display("FAIL m0_bit_seq got %h want a5", seq[7:0]); end
        if (bus.rx_data !== 32'h000000A5) begin errors++; $display("FAIL m0_rx got %h want 000000a5", bus.rx_data); end
        if (dones !== 1) begin errors++; $display("FAIL m0_done_count got %0d want 1", dones); end
        if (c0s !== 8) begin errors++; $display("FAIL m0_cpol0_count got %0d want 8", c0s); end
    endtask

    task automatic test_lsb32();
        set_mode(1'b0, 1'b1, 1'b1, 1'b0);
        start(5'd0, 1'b1, 32'h12345678);
        checks += 1;
        if (bus.s_out !== 1'b0) begin errors++; $display("FAIL l32_first_bit got %b want 0", bus.s_out); end
        run_clkgen(40);
        tick();
        checks += 5;
        if (bus.tip !== 1'b0) begin errors++; $display("FAIL l32_tip_end got %b want 0", bus.tip); end
        if (periods !== 32) begin errors++; $display("FAIL l32_periods got %0d want 32", periods); end
        if (bus.rx_data !== 32'h12345678) begin errors++; $display("FAIL l32_rx got %h want 12345678", bus.rx_data); end
        if (seq !== 32'h12345678) begin errors++; $display("FAIL l32_bit_seq got %h want 12345678", seq); end
        if (dones !== 1) begin errors++; $display("FAIL l32_done_count got %0d want 1", dones); end
    endtask

    task automatic test_last_clk();
        set_mode(1'b1, 1'b0, 1'b0, 1'b1);
        start(5'd4, 1'b1, 32'h0000000F);
        run_clkgen(40);
        tick();
        checks += 4;
        if (first_last !== 4) begin errors++; $display("FAIL lc_rise_at got %0d want 4", first_last); end
        if (bus.last_clk !== 1'b0) begin errors++; $display("FAIL lc_after got %b want 0", bus.last_clk); end
        if (bus.rx_data !== 32'h0000000F) begin errors++; $display("FAIL lc_rx got %h want 0000000f", bus.rx_data); end
        if (dones !== 1) begin errors++; $display("FAIL lc_done_count got %0d want 1", dones); end
    endtask

    task automatic test_idle_strobes();
        for (int i = 0; i < 3; i++) begin
            bus.cpol_0 = (i != 1);
            bus.cpol_1 = (i != 0);
            tick();
            bus.cpol_0 = 1'b0;
            bus.cpol_1 = 1'b0;
            tick();
            checks += 4;
            if (bus.tip !== 1'b0) begin errors++; $display("FAIL idle_tip_%0d got %b want 0", i, bus.tip); end
            if (bus.rx_data !== 32'h0000000F) begin errors++; $display("FAIL idle_rx_%0d got %h want 0000000f", i, bus.rx_data); end
            if (bus.s_out !== 1'b1) begin errors++; $display("FAIL idle_s_out_%0d got %b want 1", i, bus.s_out); end
            if ((bus.done | bus.last_clk) !== 1'b0) begin errors++; $display("FAIL idle_flags_%0d got %b want 0", i, bus.done | bus.last_clk); end
        end
    endtask

    task automatic test_go_ignored();
        set_mode(1'b1, 1'b0, 1'b1, 1'b0);
        go_at   = 3;
        both_at = 5;
        start(5'd8, 1'b0, 32'hA5);
        run_clkgen(40);
        tick();
        go_at   = -1;
        both_at = -1;
        checks += 4;
        if (bus.rx_data !== 32'h000000A5) begin errors++; $display("FAIL gi_rx got %h want 000000a5", bus.rx_data); end
        if (seq[7:0] !== 8'hA5) begin errors++; $display("FAIL gi_bit_seq got %h want a5", seq[7:0]); end
        if (periods !== 8) begin errors++; $display("FAIL gi_periods got %0d want 8", periods); end
        if (dones !== 1) begin errors++; $display("FAIL gi_done_count got %0d want 1", dones); end
        tick();
        tick();
        checks += 1;
        if (bus.tip !== 1'b0) begin errors++; $display("FAIL gi_no_restart got %b want 0", bus.tip); end
    endtask

    task automatic test_back_to_back();
        set_mode(1'b1, 1'b0, 1'b1, 1'b0);
        start(5'd8, 1'b0, 32'h5A);
        run_clkgen(40);
        checks += 2;
        if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b want 1", bus.done); end
        if (bus.rx_data !== 32'h0000005A) begin errors++; $display("FAIL b2b_rx1 got %h want 0000005a", bus.rx_data); end
        start(5'd4, 1'b1, 32'h3);
        checks += 3;
        if (bus.tip !== 1'b1) begin errors++; $display("FAIL b2b_tip got %b want 1", bus.tip); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_done_clr got %b want 0", bus.done); end
        if (bus.s_out !== 1'b1) begin errors++; $display("FAIL b2b_first_bit got %b want 1", bus.s_out); end
        run_clkgen(40);
        tick();
        checks += 2;
        if (bus.rx_data !== 32'h00000003) begin errors++; $display("FAIL b2b_rx2 got %h want 00000003", bus.rx_data); end
        if (dones !== 1) begin errors++; $display("FAIL b2b_done_count got %0d want 1", dones); end
    endtask

    task automatic test_reset_abort();
        set_mode(1'b1, 1'b0, 1'b1, 1'b0);
        start(5'd8, 1'b0, 32'hA5);
        run_clkgen(2);
        bus.cpol_0 = 1'b1;
        tick();
        bus.cpol_0 = 1'b0;
        checks += 3;
        if (bus.tip !== 1'b1) begin errors++; $display("FAIL ra_tip_mid got %b want 1", bus.tip); end
        if (bus.rx_data !== 32'h000000A0) begin errors++; $display("FAIL ra_rx_mid got %h want 000000a0", bus.rx_data); end
        if (bus.s_out !== 1'b1) begin errors++; $display("FAIL ra_s_out_mid got %b want 1", bus.s_out); end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (bus.tip !== 1'b0) begin errors++; $display("FAIL ra_tip got %b want 0", bus.tip); end
        if (bus.last_clk !== 1'b0) begin errors++; $display("FAIL ra_last_clk got %b want 0", bus.last_clk); end
        if (bus.s_out !== 1'b0) begin errors++; $display("FAIL ra_s_out got %b want 0", bus.s_out); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL ra_done got %b want 0", bus.done); end
        if (bus.rx_data !== 32'd0) begin errors++; $display("FAIL ra_rx got %h want 0", bus.rx_data); end
        dones = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks += 1;
        if (dones !== 0) begin errors++; $display("FAIL ra_no_done got %0d want 0", dones); end
        start(5'd8, 1'b0, 32'h3C);
        run_clkgen(40);
        tick();
        checks += 2;
        if (bus.rx_data !== 32'h0000003C) begin errors++; $display("FAIL ra_rx_after got %h want 0000003c", bus.rx_data); end
        if (dones !== 1) begin errors++; $display("FAIL ra_done_after got %0d want 1", dones); end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        dones          = 0;
        c0s            = 0;
        first_last     = -1;
        rst_n          = 1'b0;
        bus.go         = 1'b0;
        bus.len        = 5'd0;
        bus.lsb        = 1'b0;
        bus.cpol_0     = 1'b0;
        bus.cpol_1     = 1'b0;
        bus.tx_data    = 32'd0;
        set_mode(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_mode0();
        test_lsb32();
        test_last_clk();
        test_idle_strobes();
        test_go_ignored();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
